// File: rtl/dnn_buf_pkg.sv
// Shared destination-buffer definitions: geometry, reader FSM states and the
// stream beat payload carried through the reader's skid FIFO.
package dnn_buf_pkg;

    localparam int unsigned DST_AW       = 13;
    localparam int unsigned DST_DEPTH    = 2048;
    localparam int unsigned DST_BANK_BIT = 12;
    localparam int unsigned DST_DW       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dst_rd_state_t;

    typedef struct packed {
        logic                  last;
        logic [2*DST_DW-1:0]   data;
    } dst_beat_t;

endpackage

// File: rtl/dst_skid_fifo.sv
// Small output skid FIFO for the destination reader; simultaneous push and pop
// on a full FIFO is accepted.
module dst_skid_fifo
    import dnn_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  dst_beat_t                      wdata,
    input  logic                           pop,
    output dst_beat_t                      rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    dst_beat_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/dst_reader.sv
// Host-side read engine: walks one destination-buffer bank and streams each
// {dst_d1,dst_d0} pair out as a 64-bit valid/ready beat, yielding to the core.
module dst_reader
    import dnn_buf_pkg::*;
#(
    parameter int unsigned DEPTH      = DST_DEPTH,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         bank,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         core_busy,
    output logic                         busy,
    output logic                         done,
    output logic                         dst_v,
    output logic [DST_AW-1:0]            dst_a,
    input  logic [DST_DW-1:0]            dst_d0,
    input  logic [DST_DW-1:0]            dst_d1,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [2*DST_DW-1:0]          m_data,
    output logic                         m_last
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PEND_W = OCC_W + 1;

    dst_rd_state_t     state;
    dst_rd_state_t     state_nx;
    logic              bank_q;
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx;
    logic              inflight;
    logic              inflight_last;
    logic              is_last;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occ;
    logic [PEND_W-1:0] pending;
    dst_beat_t         push_beat;
    dst_beat_t         head;

    assign is_last   = (CNT_W'(idx) == count_q - CNT_W'(1));
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign m_data    = head.data;
    assign m_last    = head.last;
    assign busy      = (state != IDLE);
    assign push_beat = '{last: inflight_last, data: {dst_d1, dst_d0}};

    // Entries that will occupy the FIFO after this cycle, before any new issue.
    assign pending = PEND_W'(occ) + PEND_W'(inflight) - PEND_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dst_v    = 1'b0;
        dst_a    = '0;
        case (state)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                dst_v = !core_busy && (pending < PEND_W'(FIFO_DEPTH));
                if (dst_v && is_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Bank bit stays driven through DRAIN so the return mux keeps the right bank.
        if (state != IDLE) begin
            dst_a[DST_BANK_BIT] = bank_q;
            dst_a[IDX_W-1:0]    = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q        <= 1'b0;
            count_q       <= '0;
            idx           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= dst_v;
            inflight_last <= dst_v && is_last;
            done          <= ((state == IDLE) && start && (count == '0))
                          || ((state == DRAIN) && pop && head.last);
            if ((state == IDLE) && start) begin
                bank_q  <= bank;
                count_q <= count;
                idx     <= '0;
            end else if (dst_v) begin
                idx <= idx + IDX_W'(1);
            end
            assert (!(inflight && fifo_full && !pop))
                else $error("dst_reader: return data pushed into a full skid FIFO");
        end
    end

    dst_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .wdata (push_beat),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

endmodule

// File: tb/tb_dst_reader.sv
// Self-checking bench for dst_reader: a registered-read buffer model feeds the
// DUT and every run is compared against the expected in-order beat sequence.
module tb_dst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bank;
    logic [11:0] count;
    logic        core_busy;
    logic        busy;
    logic        done;
    logic        dst_v;
    logic [12:0] dst_a;
    logic [31:0] dst_d0;
    logic [31:0] dst_d1;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;

    int checks = 0;
    int passed = 0;

    dst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bank      (bank),
        .count     (count),
        .core_busy (core_busy),
        .busy      (busy),
        .done      (done),
        .dst_v     (dst_v),
        .dst_a     (dst_a),
        .dst_d0    (dst_d0),
        .dst_d1    (dst_d1),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // Destination buffer model: one-cycle read latency, output mux by current dst_a[12].
    logic [31:0] mem_d0 [8192];
    logic [31:0] mem_d1 [8192];
    logic [11:0] rd_row;
    logic        rd_v;
    always @(posedge clk) begin
        rd_v   <= dst_v;
        rd_row <= dst_a[11:0];
    end
    assign dst_d0 = rd_v ? mem_d0[{dst_a[12], rd_row}] : 32'hBAD0_BAD0;
    assign dst_d1 = rd_v ? mem_d1[{dst_a[12], rd_row}] : 32'hBAD1_BAD1;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Stimulus modes for m_ready / core_busy, applied just after each edge.
    int ready_mode = 0;
    int cb_mode    = 0;
    int pat        = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       m_ready = ($urandom_range(0, 3) != 0);
            2:       m_ready = (pat % 3 == 0);
            default: m_ready = 1'b1;
        endcase
        pat++;
        if (cb_mode == 1) core_busy = ($urandom_range(0, 3) == 0);
    end

    // Observation: everything the DUT does, recorded between clock edges.
    logic [12:0] addr_q [$];
    logic [64:0] beat_q [$];
    int          iss, acc, out_viol, stab_viol, v_under_cb;
    int          mv_cnt, busy_cnt, done_cnt, done_cyc, first_v, last_v, start_cyc;
    logic [12:0] last_a;
    logic        prev_stall;
    logic [64:0] prev_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (dst_v) begin
                addr_q.push_back(dst_a);
                last_a = dst_a;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (core_busy) v_under_cb++;
                iss++;
            end
            if (m_valid && m_ready) begin
                beat_q.push_back({m_last, m_data});
                acc++;
            end
            if (m_valid) mv_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (iss - acc > 2) out_viol++;
            if (prev_stall && (!m_valid || ({m_last, m_data} !== prev_beat))) stab_viol++;
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end
    end

    task automatic clear_mon();
        addr_q.delete();
        beat_q.delete();
        iss = 0; acc = 0; out_viol = 0; stab_viol = 0; v_under_cb = 0;
        mv_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1000;
        first_v = -1; last_v = -1; last_a = '0; prev_stall = 1'b0;
    endtask

    // Reference: entry i of bank b is read in order, last flagged on i == n-1.
    function automatic int addr_errs(input logic b, input int n);
        int e = 0;
        logic [12:0] a;
        if (addr_q.size() != n) e++;
        for (int i = 0; i < addr_q.size() && i < n; i++) begin
            a = {b, 1'b0, 11'(i)};
            if (addr_q[i] !== a) e++;
        end
        return e;
    endfunction

    function automatic int beat_errs(input logic b, input int n);
        int e = 0;
        logic [12:0] a;
        logic [64:0] x;
        if (beat_q.size() != n) e++;
        for (int i = 0; i < beat_q.size() && i < n; i++) begin
            a = {b, 1'b0, 11'(i)};
            x = {(i == n - 1), mem_d1[a], mem_d0[a]};
            if (beat_q[i] !== x) e++;
        end
        return e;
    endfunction

    task automatic pulse_start(input logic b, input int n);
        start = 1'b1;
        bank  = b;
        count = 12'(n);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, dst_v, m_valid, m_last} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, dst_v, m_valid, m_last});
        else passed++;
        checks++;
        if (dst_a !== 13'h0) $display("FAIL reset_addr: got %h expected 0000", dst_a);
        else passed++;
        checks++;
        if (m_data !== 64'h0) $display("FAIL reset_data: got %h expected 0", m_data);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int rel;
        clear_mon();
        pulse_start(1'b0, 4);
        wait_done(50);
        rel = done_cyc - start_cyc + 1;
        checks++;
        if (addr_errs(1'b0, 4) !== 0) $display("FAIL basic_addr: %0d errors, expected 0", addr_errs(1'b0, 4));
        else passed++;
        checks++;
        if (beat_errs(1'b0, 4) !== 0) $display("FAIL basic_beats: %0d errors, expected 0", beat_errs(1'b0, 4));
        else passed++;
        checks++;
        if (first_v - start_cyc + 1 !== 1) $display("FAIL basic_first_v: cycle %0d expected 1", first_v - start_cyc + 1);
        else passed++;
        checks++;
        if (last_v - first_v !== 3) $display("FAIL basic_consecutive: span %0d expected 3", last_v - first_v);
        else passed++;
        checks++;
        if (rel !== 7) $display("FAIL basic_done_time: cycle %0d expected 7", rel);
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_full_bank();
        int rel;
        clear_mon();
        pulse_start(1'b1, 2048);
        wait_done(2200);
        rel = done_cyc - start_cyc + 1;
        checks++;
        if (addr_errs(1'b1, 2048) !== 0) $display("FAIL full_addr: %0d errors, expected 0", addr_errs(1'b1, 2048));
        else passed++;
        checks++;
        if (last_a !== 13'h17FF) $display("FAIL full_last_addr: got %h expected 17ff", last_a);
        else passed++;
        checks++;
        if (beat_errs(1'b1, 2048) !== 0) $display("FAIL full_beats: %0d errors, expected 0", beat_errs(1'b1, 2048));
        else passed++;
        checks++;
        if (rel !== 2051) $display("FAIL full_done_time: cycle %0d expected 2051", rel);
        else passed++;
    endtask

    task automatic test_backpressure();
        clear_mon();
        ready_mode = 2;
        pulse_start(1'b1, 5);
        wait_done(200);
        ready_mode = 0;
        checks++;
        if (addr_errs(1'b1, 5) !== 0) $display("FAIL bp_addr: %0d errors, expected 0", addr_errs(1'b1, 5));
        else passed++;
        checks++;
        if (beat_errs(1'b1, 5) !== 0) $display("FAIL bp_beats: %0d errors, expected 0", beat_errs(1'b1, 5));
        else passed++;
        checks++;
        if (out_viol !== 0) $display("FAIL bp_outstanding: %0d violations, expected 0", out_viol);
        else passed++;
        checks++;
        if (stab_viol !== 0) $display("FAIL bp_stable: %0d violations, expected 0", stab_viol);
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_core_busy();
        clear_mon();
        pulse_start(1'b0, 8);
        for (int k = 0; k < 50 && addr_q.size() < 3; k++) @(negedge clk);
        @(posedge clk);
        #1;
        core_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        core_busy = 1'b0;
        wait_done(100);
        checks++;
        if (v_under_cb !== 0) $display("FAIL cb_issue: %0d reads under core_busy, expected 0", v_under_cb);
        else passed++;
        checks++;
        if (addr_errs(1'b0, 8) !== 0) $display("FAIL cb_addr: %0d errors, expected 0", addr_errs(1'b0, 8));
        else passed++;
        checks++;
        if (beat_errs(1'b0, 8) !== 0) $display("FAIL cb_beats: %0d errors, expected 0", beat_errs(1'b0, 8));
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL cb_done_cnt: got %0d expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_zero_and_restart();
        clear_mon();
        pulse_start(1'b1, 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 1 || done_cyc - start_cyc + 1 !== 1)
            $display("FAIL zero_done: count %0d at cycle %0d, expected 1 at 1", done_cnt, done_cyc - start_cyc + 1);
        else passed++;
        checks++;
        if (addr_q.size() + mv_cnt !== 0) $display("FAIL zero_activity: %0d reads/beats, expected 0", addr_q.size() + mv_cnt);
        else passed++;
        checks++;
        if (busy_cnt !== 0) $display("FAIL zero_busy: busy for %0d cycles, expected 0", busy_cnt);
        else passed++;
        // A second start while running must be ignored.
        clear_mon();
        pulse_start(1'b0, 6);
        @(posedge clk);
        #1;
        pulse_start(1'b1, 3);
        wait_done(100);
        checks++;
        if (addr_errs(1'b0, 6) !== 0) $display("FAIL restart_addr: %0d errors, expected 0", addr_errs(1'b0, 6));
        else passed++;
        checks++;
        if (beat_errs(1'b0, 6) !== 0) $display("FAIL restart_beats: %0d errors, expected 0", beat_errs(1'b0, 6));
        else passed++;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 1) $display("FAIL restart_done_cnt: got %0d expected 1", done_cnt);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        int rel;
        clear_mon();
        pulse_start(1'b1, 10);
        for (int k = 0; k < 50 && beat_q.size() < 2; k++) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        @(negedge clk);
        checks++;
        if ({busy, done, dst_v, m_valid, m_last} !== 5'b0 || dst_a !== 13'h0 || m_data !== 64'h0)
            $display("FAIL midreset_outputs: ctrl %b addr %h data %h expected all zero",
                     {busy, done, dst_v, m_valid, m_last}, dst_a, m_data);
        else passed++;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (done_cnt + mv_cnt + addr_q.size() !== 0)
            $display("FAIL midreset_quiet: %0d events after reset, expected 0", done_cnt + mv_cnt + addr_q.size());
        else passed++;
        clear_mon();
        pulse_start(1'b1, 3);
        wait_done(50);
        rel = done_cyc - start_cyc + 1;
        checks++;
        if (addr_errs(1'b1, 3) !== 0) $display("FAIL postreset_addr: %0d errors, expected 0", addr_errs(1'b1, 3));
        else passed++;
        checks++;
        if (beat_errs(1'b1, 3) !== 0) $display("FAIL postreset_beats: %0d errors, expected 0", beat_errs(1'b1, 3));
        else passed++;
        checks++;
        if (rel !== 6) $display("FAIL postreset_done_time: cycle %0d expected 6", rel);
        else passed++;
    endtask

    task automatic test_random();
        logic b;
        int   n;
        ready_mode = 1;
        cb_mode    = 1;
        for (int r = 0; r < 6; r++) begin
            b = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 40);
            clear_mon();
            pulse_start(b, n);
            wait_done(1000);
            checks++;
            if (addr_errs(b, n) !== 0) $display("FAIL rand%0d_addr: %0d errors, expected 0", r, addr_errs(b, n));
            else passed++;
            checks++;
            if (beat_errs(b, n) !== 0) $display("FAIL rand%0d_beats: %0d errors, expected 0", r, beat_errs(b, n));
            else passed++;
            checks++;
            if (out_viol + stab_viol !== 0)
                $display("FAIL rand%0d_flow: %0d outstanding/stability violations, expected 0", r, out_viol + stab_viol);
            else passed++;
            checks++;
            if (v_under_cb !== 0) $display("FAIL rand%0d_core_busy: %0d reads, expected 0", r, v_under_cb);
            else passed++;
            checks++;
            if (done_cnt !== 1) $display("FAIL rand%0d_done_cnt: got %0d expected 1", r, done_cnt);
            else passed++;
        end
        ready_mode = 0;
        cb_mode    = 0;
        core_busy  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bank      = 1'b0;
        count     = '0;
        core_busy = 1'b0;
        m_ready   = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            mem_d0[i] = $urandom;
            mem_d1[i] = $urandom;
        end
        clear_mon();
        test_reset();
        test_basic();
        test_full_bank();
        test_backpressure();
        test_core_busy();
        test_zero_and_restart();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
